// File: rtl/mod2011_rr_scheduler.sv
// Round-robin scheduler sharing one 300-bit mod-2011 reducer among NREQ requesters.
// Optional range check on the returned remainder: define MOD2011_SCHED_RANGECHK_EN.
module mod2011_rr_scheduler #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int DP_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*300-1:0]   req_x,
  output logic [299:0]          dp_x,
  output logic                  dp_start,
  input  logic [10:0]           dp_r,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [10:0]           res_r,
  output logic [IDW-1:0]        res_id,
  output logic                  busy,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = (DP_LAT > 0) ? 3'(DP_LAT - 1) : 3'd0;

  state_t                    state, nxt;
  logic [IDW-1:0]            rr_ptr, gnt;
  logic                      found;
  logic [2:0]                cnt;
  logic                      cap;
  logic [10:0]               res_nxt;
  logic [NREQ-1:0][299:0]    x_lane;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign x_lane[i] = req_x[300*i +: 300];
  end

  // first valid index at or after rr_ptr, cyclic
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[IDW-1:0];
      end
    end
  end

  // gated by rst so every output reads 0 while reset is held
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (found) nxt = ISSUE;
      ISSUE: nxt = (DP_LAT == 0) ? RESP : WAIT;
      WAIT:  if (cnt == 3'd0) nxt = RESP;
      RESP:  if (res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign cap       = (state == ISSUE && DP_LAT == 0) || (state == WAIT && cnt == 3'd0);
  assign dp_start  = (state == ISSUE);
  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef MOD2011_SCHED_RANGECHK_EN
  logic rng;
  assign rng = (dp_r >= 11'd2011);
  always_comb begin
    res_nxt = dp_r;
    if (rng) res_nxt = dp_r - 11'd2011;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err <= 1'b0;
    else if (cap && rng) err <= 1'b1;
  end
`else
  assign res_nxt = dp_r;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      dp_x   <= '0;
      res_r  <= '0;
      res_id <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        dp_x   <= x_lane[gnt];
        res_id <= gnt;
        rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end
      if (state == ISSUE) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (cap) res_r <= res_nxt;
    end
  end
endmodule

// File: tb/tb_mod2011_rr_scheduler.sv
// Scoreboard bench: one scheduler with a combinational reducer, one with 3-cycle latency.
module tb_mod2011_rr_scheduler;
  typedef struct { logic [1:0] id; logic [10:0] r; } exp_t;

`ifdef MOD2011_SCHED_RANGECHK_EN
  localparam int EXP6 = 2, EXPERR = 1;
`else
  localparam int EXP6 = 2013, EXPERR = 0;
`endif

  logic clk = 0, rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] req_valid0, req_ready0, req_valid3, req_ready3;
  logic [1199:0] x0, x3;
  logic [299:0] dp_x0, dp_x3;
  logic dp_start0, dp_start3, res_valid0, res_valid3, res_ready0, res_ready3;
  logic busy0, busy3, err0, err3, ovr0;
  logic [10:0] dp_r0, dp_r3, res_r0, res_r3;
  logic [1:0] res_id0, res_id3;

  // bench reducer model
  assign dp_r0 = ovr0 ? 11'd2013 : 11'(dp_x0 % 300'd2011);
  assign dp_r3 = 11'(dp_x3 % 300'd2011);

  mod2011_rr_scheduler #(.NREQ(4), .IDW(2), .DP_LAT(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_x(x0),
    .dp_x(dp_x0), .dp_start(dp_start0), .dp_r(dp_r0), .res_valid(res_valid0),
    .res_ready(res_ready0), .res_r(res_r0), .res_id(res_id0), .busy(busy0), .err(err0));

  mod2011_rr_scheduler #(.NREQ(4), .IDW(2), .DP_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_x(x3),
    .dp_x(dp_x3), .dp_start(dp_start3), .dp_r(dp_r3), .res_valid(res_valid3),
    .res_ready(res_ready3), .res_r(res_r3), .res_id(res_id3), .busy(busy3), .err(err3));

  int total = 0, pass = 0;
  exp_t sb0[$], sb3[$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic int p2mod(int e);
    int r = 1;
    repeat (e) r = (r * 2) % 2011;
    return r;
  endfunction

  function automatic exp_t mk(int id, int r);
    exp_t e;
    e.id = 2'(id);
    e.r  = 11'(r);
    return e;
  endfunction

  // monitor: pops expected entry on every accepted result
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && res_valid0 && res_ready0) begin
      if (sb0.size() == 0) chk("m0_extra", 1, 0);
      else begin e = sb0.pop_front(); chk("m0_id", res_id0, e.id); chk("m0_r", res_r0, e.r); end
    end
    if (!rst && res_valid3 && res_ready3) begin
      if (sb3.size() == 0) chk("m3_extra", 1, 0);
      else begin e = sb3.pop_front(); chk("m3_id", res_id3, e.id); chk("m3_r", res_r3, e.r); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, badt, bads, ng, last, t;
    logic [299:0] v;
    rst = 1; req_valid0 = 0; req_valid3 = 0; x0 = '0; x3 = '0;
    res_ready0 = 1; res_ready3 = 1; ovr0 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {busy0, busy3, dp_start0, dp_start3, res_valid0, res_valid3,
                     err0, err3, |dp_x0, |dp_x3, req_ready0, req_ready3}, 0);
    chk("rst_res", {res_r0, res_r3, res_id0, res_id3}, 0);
    @(negedge clk) rst = 0;

    // quiet after reset
    bad = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (busy0 | busy3 | dp_start0 | dp_start3 | res_valid0 | res_valid3 |
          err0 | err3 | (|req_ready0) | (|req_ready3)) bad++;
    end
    chk("idle_quiet", bad, 0);

    // single request, zero latency
    @(negedge clk);
    x0[2*300 +: 300] = 300'd2012; req_valid0 = 4'b0100;
    #1 chk("t2_ready", req_ready0, 4'b0100);
    sb0.push_back(mk(2, 1));
    @(negedge clk); req_valid0 = 0;
    #1 chk("t2_start", {dp_start0, res_valid0}, 2'b10);
    chk("t2_dpx", dp_x0[63:0], 2012);
    @(negedge clk); #1 chk("t2_resv", {dp_start0, res_valid0}, 2'b01);
    @(negedge clk); #1 chk("t2_idle", busy0, 0);

    rst = 1; @(negedge clk) rst = 0;

    // four contenders, round-robin from index 0
    for (int i = 0; i < 4; i++) x0[i*300 +: 300] = 300'(2011 * (i + 5) + 10 * i + 3);
    for (int i = 0; i < 8; i++) sb0.push_back(mk(i % 4, 10 * (i % 4) + 3));
    @(negedge clk); req_valid0 = 4'hF;
    ng = 0; last = 0; bad = 0;
    for (int c = 0; c < 40 && ng < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (|req_ready0) begin
        if (req_ready0 != 4'(1 << (ng % 4))) bad++;
        if (ng > 0 && cyc - last != 3) bad++;
        last = cyc; ng++;
      end
    end
    chk("t3_grants", ng, 8);
    chk("t3_order", bad, 0);
    @(negedge clk) req_valid0 = 0;
    repeat (6) @(negedge clk);
    #3 chk("t3_drain", sb0.size(), 0);

    // DP_LAT=3 with a 10-cycle consumer stall
    res_ready3 = 0;
    @(negedge clk);
    v = '0; v[299] = 1'b1; x3[299:0] = v; req_valid3 = 4'b0001;
    #1 chk("t4_ready", req_ready3, 4'b0001);
    t = cyc;
    sb3.push_back(mk(0, p2mod(299)));
    badt = 0; bads = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) req_valid3 = 4'hF;
      #1;
      if (k == 1) chk("t4_start", {dp_start3, busy3}, 2'b11);
      if (res_valid3 !== (cyc - t >= 5)) badt++;
      if (req_ready3 != 0) bads++;
      if (k >= 5 && (res_r3 != 11'(p2mod(299)) || res_id3 != 0 || !busy3)) bads++;
    end
    chk("t4_timing", badt, 0);
    chk("t4_stall", bads, 0);
    @(negedge clk); req_valid3 = 0; res_ready3 = 1;
    @(negedge clk); #3 chk("t4_done", {busy3, 6'(sb3.size())}, 0);

    // reset during WAIT; rr_ptr must return to 0
    x3[1*300 +: 300] = 300'(2011 * 3 + 77); x3[2*300 +: 300] = 300'd500;
    @(negedge clk); req_valid3 = 4'b0110;
    #1 chk("t5_ready_a", req_ready3, 4'b0010);
    repeat (2) @(negedge clk);
    #1 chk("t5_inwait", {busy3, dp_start3, res_valid3}, 3'b100);
    rst = 1;
    #1 chk("t5_rst_out", {busy3, dp_start3, res_valid3, req_ready3, |dp_x3, res_r3, res_id3, err3}, 0);
    @(negedge clk) rst = 0;
    #1 chk("t5_ready_b", req_ready3, 4'b0010);
    sb3.push_back(mk(1, 77));
    @(negedge clk) req_valid3 = 0;
    repeat (6) @(negedge clk);
    #3 chk("t5_drain", sb3.size(), 0);

    // out-of-range reducer output
    ovr0 = 1; x0[299:0] = 300'd5;
    @(negedge clk) req_valid0 = 4'b0001;
    #1 chk("t6_ready", req_ready0, 4'b0001);
    sb0.push_back(mk(0, EXP6));
    @(negedge clk) req_valid0 = 0;
    repeat (4) @(negedge clk);
    ovr0 = 0;
    #1 chk("t6_err", err0, EXPERR);
    x0[299:0] = 300'(2011 + 9);
    @(negedge clk) req_valid0 = 4'b0001;
    #1 chk("t6_ready2", req_ready0, 4'b0001);
    sb0.push_back(mk(0, 9));
    @(negedge clk) req_valid0 = 0;
    repeat (4) @(negedge clk);
    #3 chk("t6_sticky", {err0, 6'(sb0.size())}, {1'(EXPERR), 6'd0});
    rst = 1; @(negedge clk) rst = 0;
    #1 chk("t6_rst", err0, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
